// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: architectural PC register and one-word-per-instruction fetch sequencer.
// Optional macro FETCH_MISALIGN_CHECK_EN traps misaligned load targets into S_ERR.
module pc_fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] next_pc,
   input  logic        pc_load,
   output logic [63:0] PC,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_gnt,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [63:0] instr_pc,
   output logic [31:0] fetch_cnt,
   output logic        fetch_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_HOLD,
      S_ERR
   } state_t;

   state_t      state;
   logic [63:0] load_pc;
   logic        misalign;

`ifdef FETCH_MISALIGN_CHECK_EN
   // Misaligned targets are kept verbatim so the faulting PC is visible.
   assign load_pc  = next_pc;
   assign misalign = (next_pc[1:0] != 2'b00);
`else
   // Low bits are dropped, so every load lands on a word boundary.
   logic unused_low;
   assign unused_low = ^next_pc[1:0];
   assign load_pc    = {next_pc[63:2], 2'b00};
   assign misalign   = 1'b0;
`endif

   // The fetch address is the PC register itself, never a live input.
   assign imem_addr = PC;

   // Fetch FSM with all outputs registered alongside the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         PC          <= RESET_PC;
         imem_req    <= 1'b0;
         instr_valid <= 1'b0;
         instr       <= 32'h0;
         instr_pc    <= 64'h0;
         fetch_cnt   <= 32'h0;
         fetch_err   <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               state    <= S_REQ;
               imem_req <= 1'b1;
            end
            S_REQ: begin
               if (imem_gnt) begin
                  instr       <= imem_rdata;
                  instr_pc    <= PC;
                  instr_valid <= 1'b1;
                  fetch_cnt   <= fetch_cnt + 32'd1;
                  imem_req    <= 1'b0;
                  state       <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (pc_load) begin
                  PC          <= load_pc;
                  instr_valid <= 1'b0;
                  if (misalign) begin
                     fetch_err <= 1'b1;
                     imem_req  <= 1'b0;
                     state     <= S_ERR;
                  end else begin
                     imem_req <= 1'b1;
                     state    <= S_REQ;
                  end
               end
            end
            S_ERR: begin
               imem_req    <= 1'b0;
               instr_valid <= 1'b0;
            end
            default: begin
               state    <= S_IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed checks of reset, fetch handshake, redirects,
// reset dominance, misaligned targets and fetch counter wrap.
module tb_pc_fetch_unit;

   logic        clk;
   logic        reset;
   logic [63:0] next_pc;
   logic        pc_load;
   logic [63:0] PC;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_gnt;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [63:0] instr_pc;
   logic [31:0] fetch_cnt;
   logic        fetch_err;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   pc_fetch_unit #(.RESET_PC(64'h1000)) dut (
      .clk         (clk),
      .reset       (reset),
      .next_pc     (next_pc),
      .pc_load     (pc_load),
      .PC          (PC),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rdata  (imem_rdata),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .fetch_cnt   (fetch_cnt),
      .fetch_err   (fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and land on the following falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      reset      = 1'b1;
      next_pc    = 64'h0;
      pc_load    = 1'b0;
      imem_gnt   = 1'b0;
      imem_rdata = 32'h0;
      tick();
      tick();
      chk("rst_pc", PC, 64'h1000);
      chk("rst_req", imem_req, 1'b0);
      chk("rst_addr", imem_addr, 64'h1000);
      chk("rst_valid", instr_valid, 1'b0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_ipc", instr_pc, 64'h0);
      chk("rst_cnt", fetch_cnt, 32'h0);
      chk("rst_err", fetch_err, 1'b0);

      // First request one cycle after reset release.
      reset = 1'b0;
      tick();
      chk("req1", imem_req, 1'b1);
      chk("addr1", imem_addr, 64'h1000);
      imem_gnt   = 1'b1;
      imem_rdata = 32'h00500093;
      tick();
      chk("valid1", instr_valid, 1'b1);
      chk("instr1", instr, 32'h00500093);
      chk("ipc1", instr_pc, 64'h1000);
      chk("cnt1", fetch_cnt, 32'd1);
      chk("req_hold", imem_req, 1'b0);

      // Grant while holding is ignored.
      imem_rdata = 32'hDEADBEEF;
      tick();
      chk("gnt_ign_instr", instr, 32'h00500093);
      chk("gnt_ign_cnt", fetch_cnt, 32'd1);

      // Sequential load, then a grant delayed by five cycles.
      imem_gnt = 1'b0;
      pc_load  = 1'b1;
      next_pc  = 64'h1004;
      tick();
      chk("seq_pc", PC, 64'h1004);
      chk("seq_addr", imem_addr, 64'h1004);
      chk("seq_req", imem_req, 1'b1);
      chk("seq_valid", instr_valid, 1'b0);
      next_pc = 64'h2000;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("wait_req", imem_req, 1'b1);
         chk("wait_addr", imem_addr, 64'h1004);
      end
      chk("ld_in_req_pc", PC, 64'h1004);
      pc_load    = 1'b0;
      imem_gnt   = 1'b1;
      imem_rdata = 32'h00100113;
      tick();
      chk("instr2", instr, 32'h00100113);
      chk("ipc2", instr_pc, 64'h1004);
      chk("cnt2", fetch_cnt, 32'd2);

      // Branch redirect at minimum instruction period.
      imem_gnt = 1'b0;
      pc_load  = 1'b1;
      next_pc  = 64'h0FF0;
      tick();
      chk("br_addr", imem_addr, 64'h0FF0);
      chk("br_req", imem_req, 1'b1);
      pc_load    = 1'b0;
      imem_gnt   = 1'b1;
      imem_rdata = 32'h00000013;
      tick();
      chk("br_ipc", instr_pc, 64'h0FF0);
      chk("cnt3", fetch_cnt, 32'd3);

      // Reset in the same cycle as a grant discards the word.
      imem_gnt = 1'b0;
      pc_load  = 1'b1;
      next_pc  = 64'h1008;
      tick();
      pc_load    = 1'b0;
      reset      = 1'b1;
      imem_gnt   = 1'b1;
      imem_rdata = 32'h12345678;
      tick();
      chk("rg_valid", instr_valid, 1'b0);
      chk("rg_cnt", fetch_cnt, 32'd0);
      chk("rg_pc", PC, 64'h1000);
      chk("rg_instr", instr, 32'h0);
      reset    = 1'b0;
      imem_gnt = 1'b0;
      tick();
      imem_gnt   = 1'b1;
      imem_rdata = 32'h00208193;
      tick();
      chk("post_rst_cnt", fetch_cnt, 32'd1);
      imem_gnt = 1'b0;

      // Misaligned load target.
      pc_load = 1'b1;
      next_pc = 64'h1006;
      tick();
      pc_load = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("mis_pc", PC, 64'h1006);
      chk("mis_err", fetch_err, 1'b1);
      chk("mis_valid", instr_valid, 1'b0);
      pc_load  = 1'b1;
      imem_gnt = 1'b1;
      next_pc  = 64'h3000;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("mis_req", imem_req, 1'b0);
      end
      chk("mis_pc_held", PC, 64'h1006);
      chk("mis_err_held", fetch_err, 1'b1);
      pc_load  = 1'b0;
      imem_gnt = 1'b0;
      reset    = 1'b1;
      tick();
      chk("mis_rst_err", fetch_err, 1'b0);
      reset = 1'b0;
      tick();
      imem_gnt = 1'b1;
      tick();
      chk("mis_rst_cnt", fetch_cnt, 32'd1);
      imem_gnt = 1'b0;
`else
      chk("mis_pc", PC, 64'h1004);
      chk("mis_err", fetch_err, 1'b0);
      chk("mis_req", imem_req, 1'b1);
      imem_gnt = 1'b1;
      tick();
      chk("mis_cnt", fetch_cnt, 32'd2);
      imem_gnt = 1'b0;
`endif

      // Counter wrap via backdoor preload while holding.
      force dut.fetch_cnt = 32'hFFFF_FFFF;
      #1;
      release dut.fetch_cnt;
      #1;
      chk("preload", fetch_cnt, 32'hFFFF_FFFF);
      pc_load = 1'b1;
      next_pc = 64'h2000;
      tick();
      pc_load  = 1'b0;
      imem_gnt = 1'b1;
      tick();
      chk("wrap_cnt", fetch_cnt, 32'h0);
      chk("wrap_ipc", instr_pc, 64'h2000);
      imem_gnt = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter register and instruction-fetch sequencer for the sequential RISC-V core. It holds the architectural PC, feeds it to the next-PC logic, issues one instruction-memory read per instruction through a req/gnt handshake, and presents the fetched word to decode. It commits a new PC only when the next-PC logic's result is loaded at instruction completion.

## Interface
- RESET_PC, 64'h0: PC value after reset.
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- next_pc  in  64  next-PC value from the next-PC logic (PC+4 or branch target).
- pc_load  in  1  instruction-complete strobe; loads next_pc into PC.
- PC  out  64  current architectural PC (to next-PC logic and to the branch target adder).
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  64  fetch address; equals PC.
- imem_gnt  in  1  memory returns imem_rdata this cycle; valid only while imem_req=1.
- imem_rdata  in  32  instruction word.
- instr_valid  out  1  instr/instr_pc hold a fetched instruction.
- instr  out  32  fetched instruction to decode.
- instr_pc  out  64  PC of instr.
- fetch_cnt  out  32  count of completed fetches, wraps at 2^32.
- fetch_err  out  1  sticky misaligned-target flag (see Configuration).

## Operation
- States: S_IDLE, S_REQ, S_HOLD, S_ERR.
- S_IDLE: outputs quiet; unconditional → S_REQ next cycle.
- S_REQ: imem_req=1, imem_addr=PC. Waits indefinitely for imem_gnt. On imem_gnt: instr<=imem_rdata, instr_pc<=PC, instr_valid<=1, fetch_cnt<=fetch_cnt+1, → S_HOLD.
- S_HOLD: imem_req=0; instr/instr_pc/instr_valid stable. On pc_load: PC<=next_pc, instr_valid<=0, → S_REQ (or S_ERR, see Configuration).
- S_ERR: imem_req=0, instr_valid=0, PC holds loaded value; exits only by reset.
- pc_load in S_IDLE, S_REQ or S_ERR: ignored; PC unchanged.
- imem_gnt outside S_REQ: ignored.
- imem_rdata sampled only in the gnt cycle; no other cycle affects instr.
- PC changes only on pc_load in S_HOLD; it is stable through S_REQ and S_HOLD so combinational next-PC logic sees a constant PC for the whole instruction.

## Timing
- Reset values: PC=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, fetch_cnt=0, fetch_err=0, state=S_IDLE.
- Reset dominates every other input in the same cycle, including a gnt in S_REQ (word discarded, fetch_cnt not incremented).
- First imem_req: cycle after reset deasserts.
- Fetch latency: gnt at edge N → instr_valid=1 after edge N.
- pc_load at edge M in S_HOLD → PC=next_pc and imem_req=1 with new address after edge M.
- Minimum instruction period 2 cycles (gnt in first S_REQ cycle, pc_load in first S_HOLD cycle).
- imem_req, imem_addr, PC and instr* are driven from registered state only; no combinational path from any input to any output.
- fetch_cnt wraps 32'hFFFF_FFFF → 0.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: on pc_load in S_HOLD with next_pc[1:0]!=2'b00, PC<=next_pc unmodified, fetch_err<=1, → S_ERR; no request is issued. fetch_err stays 1 until reset.
- Undefined: PC<={next_pc[63:2],2'b00} on every load; fetch_err tied 0; S_ERR unreachable.

## Test plan
- Reset with RESET_PC=64'h1000: after reset release, cycle 1 imem_req=1, imem_addr=64'h1000; gnt with rdata=32'h00500093 → instr_valid=1, instr=32'h00500093, instr_pc=64'h1000, fetch_cnt=1.
- Sequential stream: pc_load with next_pc=64'h1004 in S_HOLD → next cycle imem_addr=64'h1004, instr_valid=0; gnt delayed 5 cycles → imem_req held 1 and addr stable throughout.
- Branch redirect: in S_HOLD at PC=64'h1004, pc_load with next_pc=64'h0FF0 → imem_addr=64'h0FF0; pc_load asserted during S_REQ → PC unchanged.
- Reset mid-fetch: reset asserted in same cycle as imem_gnt → instr_valid=0, fetch_cnt=0, PC=RESET_PC.
- Misaligned target: next_pc=64'h1006 on pc_load → with FETCH_MISALIGN_CHECK_EN fetch_err=1, imem_req stays 0 for 10 cycles; without it PC=64'h1004, fetch_err=0.
- Counter wrap: force 2^32-1 fetches (or preload via backdoor) → next gnt gives fetch_cnt=0.
